// File: rtl/pm_irq_pkg.sv
// Shared definitions for the Pokemon Mini interrupt controller: FSM states,
// register-map offsets and the source-to-priority-group table.
package pm_irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACKED
  } irq_fsm_t;

  localparam int MAX_SOURCES  = 32;
  localparam int REG_PRIO_OFS = 0;

  function automatic int bytes_for(input int bits);
    return (bits + 7) / 8;
  endfunction

  // Priority group of each interrupt source (NMI, blitter, timers, 256 Hz, IR, keypad).
  function automatic int src_group(input int src);
    if (src <= 2)       return 0;
    else if (src <= 4)  return 3;
    else if (src <= 6)  return 2;
    else if (src <= 8)  return 1;
    else if (src <= 10) return 0;
    else if (src <= 14) return 7;
    else if (src <= 18) return 8;
    else if (src <= 20) return 6;
    else if (src <= 28) return 5;
    else                return 4;
  endfunction

endpackage

// File: rtl/irq_priority_select.sv
// Combinational winner selection: highest priority among eligible sources,
// ties resolved towards the lowest source index.
module irq_priority_select #(
  parameter int NUM_SOURCES = 32,
  parameter int PRIO_WIDTH  = 2
) (
  input  logic [NUM_SOURCES-1:0]                 eligible_i,
  input  logic [NUM_SOURCES-1:0][PRIO_WIDTH-1:0] prio_i,
  output logic [4:0]                             win_idx_o,
  output logic [PRIO_WIDTH-1:0]                  win_level_o,
  output logic                                   win_valid_o
);

  logic [4:0]            best_idx;
  logic [PRIO_WIDTH-1:0] best_level;
  logic                  best_valid;

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    best_idx   = '0;
    best_level = '0;
    best_valid = 1'b0;
    // Ascending scan with strict '>' keeps the lowest index on a tie.
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (eligible_i[i] && (!best_valid || (prio_i[i] > best_level))) begin
        best_valid = 1'b1;
        best_idx   = 5'(i);
        best_level = prio_i[i];
      end
    end
  end

  assign win_idx_o   = best_idx;
  assign win_level_o = best_level;
  assign win_valid_o = best_valid;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt controller: edge-latched pending flags, bus-mapped priority/enable/
// pending registers, and a registered req/ack handshake towards the CPU.
module irq_arbiter
  import pm_irq_pkg::*;
#(
  parameter int          NUM_SOURCES = 32,
  parameter int          NUM_GROUPS  = 9,
  parameter int          PRIO_WIDTH  = 2,
  parameter logic [23:0] BASE_ADDR   = 24'h2020
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_src,
  input  logic                   bus_write,
  input  logic                   bus_read,
  input  logic [23:0]            bus_address_in,
  input  logic [7:0]             bus_data_in,
  output logic [7:0]             bus_data_out,
  input  logic [PRIO_WIDTH-1:0]  cpu_level,
  output logic                   cpu_irq_req,
  output logic [4:0]             cpu_irq_vector,
  output logic [PRIO_WIDTH-1:0]  cpu_irq_level,
  input  logic                   cpu_irq_ack
);

  localparam int PRIO_BITS  = NUM_GROUPS * PRIO_WIDTH;
  localparam int PRIO_BYTES = bytes_for(PRIO_BITS);
  localparam int SRC_BYTES  = bytes_for(NUM_SOURCES);
  localparam int EN_OFS     = REG_PRIO_OFS + PRIO_BYTES;
  localparam int PEND_OFS   = EN_OFS + SRC_BYTES;
  localparam int MAP_BYTES  = PEND_OFS + SRC_BYTES;

  logic [PRIO_BITS-1:0]   prio_q, prio_d;
  logic [NUM_SOURCES-1:0] enable_q, enable_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] src_prev_q;
  logic [NUM_SOURCES-1:0] edge_set, pend_clr;

  irq_fsm_t              state_q;
  logic                  req_q;
  logic [4:0]            vector_q;
  logic [PRIO_WIDTH-1:0] level_q;

  // Reads carry no side effects, so the read strobe is not needed.
  logic unused_bus_read;
  assign unused_bus_read = bus_read;

  logic [23:0] ofs;
  int          byte_sel;
  assign ofs      = bus_address_in - BASE_ADDR;
  assign byte_sel = (ofs < 24'(MAP_BYTES)) ? int'(ofs) : -1;

  always_comb begin
    bus_data_out = '0;
    for (int b = 0; b < PRIO_BITS; b++) begin
      if (byte_sel == REG_PRIO_OFS + b / 8) bus_data_out[3'(b % 8)] = prio_q[b];
    end
    for (int s = 0; s < NUM_SOURCES; s++) begin
      if (byte_sel == EN_OFS + s / 8)   bus_data_out[3'(s % 8)] = enable_q[s];
      if (byte_sel == PEND_OFS + s / 8) bus_data_out[3'(s % 8)] = pending_q[s];
    end
  end

  assign edge_set = irq_src & ~src_prev_q;

  always_comb begin
    prio_d   = prio_q;
    enable_d = enable_q;
    pend_clr = '0;
    if (bus_write) begin
      for (int b = 0; b < PRIO_BITS; b++) begin
        if (byte_sel == REG_PRIO_OFS + b / 8) prio_d[b] = bus_data_in[3'(b % 8)];
      end
      for (int s = 0; s < NUM_SOURCES; s++) begin
        if (byte_sel == EN_OFS + s / 8)   enable_d[s] = bus_data_in[3'(s % 8)];
        if (byte_sel == PEND_OFS + s / 8) pend_clr[s] = bus_data_in[3'(s % 8)];
      end
    end
    // A new edge in the same cycle as a W1C clear keeps the flag set.
    pending_d = (pending_q & ~pend_clr) | edge_set;
  end

  // NOTE: sequential state is updated only with non-blocking assignments inside always_ff.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q     <= '0;
      enable_q   <= '0;
      pending_q  <= '0;
      src_prev_q <= '0;
    end else begin
      prio_q     <= prio_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      src_prev_q <= irq_src;
    end
  end

  logic [NUM_SOURCES-1:0]                 eligible;
  logic [NUM_SOURCES-1:0][PRIO_WIDTH-1:0] src_prio;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    localparam int GRP = src_group(i);
    if (GRP < NUM_GROUPS) begin : g_map
      assign src_prio[i] = prio_q[GRP*PRIO_WIDTH +: PRIO_WIDTH];
    end else begin : g_none
      assign src_prio[i] = '0;
    end
    assign eligible[i] = pending_q[i] & enable_q[i] &
                         (src_prio[i] != '0) & (src_prio[i] > cpu_level);
  end

  logic [4:0]            win_idx;
  logic [PRIO_WIDTH-1:0] win_level;
  logic                  win_valid;

  irq_priority_select #(
    .NUM_SOURCES (NUM_SOURCES),
    .PRIO_WIDTH  (PRIO_WIDTH)
  ) u_select (
    .eligible_i  (eligible),
    .prio_i      (src_prio),
    .win_idx_o   (win_idx),
    .win_level_o (win_level),
    .win_valid_o (win_valid)
  );

  logic [MAX_SOURCES-1:0] elig_pad;
  logic                   held_eligible;
  assign elig_pad      = MAX_SOURCES'(eligible);
  assign held_eligible = elig_pad[vector_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      vector_q <= '0;
      level_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q  <= REQ;
            req_q    <= 1'b1;
            vector_q <= win_idx;
            level_q  <= win_level;
          end
        end
        REQ: begin
          // No pre-emption: a better source waits until the FSM is back in IDLE.
          if (cpu_irq_ack) begin
            state_q <= ACKED;
            req_q   <= 1'b0;
          end else if (!held_eligible) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        ACKED: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_irq_req    = req_q;
  assign cpu_irq_vector = vector_q;
  assign cpu_irq_level  = level_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus randomized
// rounds compared against a register-level reference model.
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] irq_src = '0;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [23:0] bus_address_in = '0;
  logic [7:0]  bus_data_in = '0;
  logic [7:0]  bus_data_out;
  logic [1:0]  cpu_level = '0;
  logic        cpu_irq_req;
  logic [4:0]  cpu_irq_vector;
  logic [1:0]  cpu_irq_level;
  logic        cpu_irq_ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [23:0] m_prio = '0;
  logic [31:0] m_en   = '0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_prev = '0;
  localparam logic [23:0] PRIO_MASK = 24'h03FFFF;

  irq_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .irq_src        (irq_src),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .cpu_level      (cpu_level),
    .cpu_irq_req    (cpu_irq_req),
    .cpu_irq_vector (cpu_irq_vector),
    .cpu_irq_level  (cpu_irq_level),
    .cpu_irq_ack    (cpu_irq_ack)
  );

  always #50 clk = ~clk;

  function automatic int grp_of(input int i);
    if (i <= 2)       return 0;
    else if (i <= 4)  return 3;
    else if (i <= 6)  return 2;
    else if (i <= 8)  return 1;
    else if (i <= 10) return 0;
    else if (i <= 14) return 7;
    else if (i <= 18) return 8;
    else if (i <= 20) return 6;
    else if (i <= 28) return 5;
    else              return 4;
  endfunction

  function automatic int prio_of(input int i);
    return int'(m_prio[grp_of(i)*2 +: 2]);
  endfunction

  // Highest priority above cpu_level among pending+enabled sources; lowest index on ties.
  function automatic int model_winner();
    int best, bestp;
    best = -1;
    bestp = 0;
    for (int i = 0; i < 32; i++) begin
      if (m_pend[i] && m_en[i] && prio_of(i) > int'(cpu_level) && prio_of(i) > bestp) begin
        best  = i;
        bestp = prio_of(i);
      end
    end
    return best;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [23:0] a);
    int off;
    off = int'(a) - 32'h2020;
    if (off >= 0 && off < 3)  return m_prio[off*8 +: 8];
    if (off >= 3 && off < 7)  return m_en[(off-3)*8 +: 8];
    if (off >= 7 && off < 11) return m_pend[(off-7)*8 +: 8];
    return 8'h00;
  endfunction

  function automatic void model_update(input logic w, input logic [23:0] a,
                                       input logic [7:0] d, input logic [31:0] s);
    int off;
    logic [31:0] clr, set;
    clr = '0;
    off = int'(a) - 32'h2020;
    if (w) begin
      if (off >= 0 && off < 3)  m_prio[off*8 +: 8] = d;
      if (off >= 3 && off < 7)  m_en[(off-3)*8 +: 8] = d;
      if (off >= 7 && off < 11) clr[(off-7)*8 +: 8] = d;
      m_prio = m_prio & PRIO_MASK;
    end
    set    = s & ~m_prev;
    m_pend = (m_pend & ~clr) | set;
    m_prev = s;
  endfunction

  function automatic void model_reset();
    m_prio = '0;
    m_en   = '0;
    m_pend = '0;
    m_prev = '0;
  endfunction

  task automatic tick();
    logic w;
    logic [23:0] a;
    logic [7:0] d;
    logic [31:0] s;
    w = bus_write;
    a = bus_address_in;
    d = bus_data_in;
    s = irq_src;
    @(posedge clk);
    #1;
    if (reset) model_update(w, a, d, s);
  endtask

  task automatic bus_wr(input logic [23:0] a, input logic [7:0] d);
    bus_address_in = a;
    bus_data_in    = d;
    bus_write      = 1'b1;
    tick();
    bus_write      = 1'b0;
  endtask

  task automatic rd_check(input logic [23:0] a, input string name);
    logic [7:0] exp;
    bus_read       = 1'b1;
    bus_address_in = a;
    #1;
    exp = exp_byte(a);
    n_tests++;
    if (bus_data_out !== exp) begin
      n_fail++;
      $display("FAIL %s @%06h: got %02h expected %02h", name, a, bus_data_out, exp);
    end
    bus_read = 1'b0;
  endtask

  task automatic wait_req(input int max_cycles, input string name);
    for (int k = 0; k < max_cycles && cpu_irq_req !== 1'b1; k++) tick();
    n_tests++;
    if (cpu_irq_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: req timeout got %b expected 1", name, cpu_irq_req);
    end
  endtask

  task automatic expect_no_req(input int cycles, input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (cpu_irq_req !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL %s: req seen got 1 expected 0", name);
    end
  endtask

  task automatic quiesce();
    irq_src   = '0;
    cpu_level = 2'd3;
    tick();
    tick();
    for (int b = 0; b < 4; b++) bus_wr(24'h2027 + 24'(b), 8'hFF);
    tick();
    n_tests++;
    if (cpu_irq_req !== 1'b0) begin
      n_fail++;
      $display("FAIL quiesce: req got %b expected 0", cpu_irq_req);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (cpu_irq_req !== 1'b0 || cpu_irq_vector !== 5'd0 || cpu_irq_level !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b vec=%0d lvl=%0d expected 0/0/0",
               cpu_irq_req, cpu_irq_vector, cpu_irq_level);
    end
    for (int a = 32'h2020; a <= 32'h202A; a++) rd_check(24'(a), "reset_regs");
    rd_check(24'h201F, "outside_low");
    rd_check(24'h202B, "outside_high");
    rd_check(24'hFFFFFF, "outside_top");
  endtask

  task automatic test_single();
    bus_wr(24'h2020, 8'h0C);
    bus_wr(24'h2023, 8'h80);
    rd_check(24'h2020, "prio_rw");
    rd_check(24'h2023, "enable_rw");
    cpu_level  = 2'd0;
    irq_src[7] = 1'b1;
    tick();
    irq_src[7] = 1'b0;
    n_tests++;
    if (cpu_irq_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: req got %b expected 0 one cycle after edge", cpu_irq_req);
    end
    rd_check(24'h2027, "single_pending");
    n_tests++;
    if (exp_byte(24'h2027) !== 8'h80) begin
      n_fail++;
      $display("FAIL single_model_pending: got %02h expected 80", exp_byte(24'h2027));
    end
    tick();
    n_tests++;
    if (cpu_irq_req !== 1'b1 || cpu_irq_vector !== 5'd7 || cpu_irq_level !== 2'd3) begin
      n_fail++;
      $display("FAIL single_req: got req=%b vec=%0d lvl=%0d expected 1/7/3",
               cpu_irq_req, cpu_irq_vector, cpu_irq_level);
    end
    tick();
    n_tests++;
    if (cpu_irq_req !== 1'b1 || cpu_irq_vector !== 5'd7) begin
      n_fail++;
      $display("FAIL single_hold: got req=%b vec=%0d expected 1/7", cpu_irq_req, cpu_irq_vector);
    end
    cpu_irq_ack = 1'b1;
    tick();
    cpu_irq_ack = 1'b0;
    n_tests++;
    if (cpu_irq_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack: req got %b expected 0", cpu_irq_req);
    end
    rd_check(24'h2027, "ack_keeps_pending");
    bus_wr(24'h2027, 8'h80);
    n_tests++;
    if (cpu_irq_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_acked_gap: req got %b expected 0", cpu_irq_req);
    end
    rd_check(24'h2027, "single_w1c");
    expect_no_req(4, "single_no_rereq");
  endtask

  task automatic test_arbitration();
    quiesce();
    bus_wr(24'h2020, 8'h4C);
    bus_wr(24'h2023, 8'h88);
    cpu_level = 2'd0;
    irq_src[3] = 1'b1;
    irq_src[7] = 1'b1;
    tick();
    irq_src = '0;
    wait_req(4, "arb_prio_req");
    n_tests++;
    if (cpu_irq_vector !== 5'd7 || cpu_irq_level !== 2'd3) begin
      n_fail++;
      $display("FAIL arb_prio: got vec=%0d lvl=%0d expected 7/3", cpu_irq_vector, cpu_irq_level);
    end
    quiesce();
    bus_wr(24'h2023, 8'h80);
    bus_wr(24'h2024, 8'h01);
    cpu_level = 2'd0;
    irq_src[7] = 1'b1;
    irq_src[8] = 1'b1;
    tick();
    irq_src = '0;
    wait_req(4, "arb_tie_req");
    n_tests++;
    if (cpu_irq_vector !== 5'd7 || cpu_irq_level !== 2'd3) begin
      n_fail++;
      $display("FAIL arb_tie: got vec=%0d lvl=%0d expected 7/3", cpu_irq_vector, cpu_irq_level);
    end
  endtask

  task automatic test_masking();
    quiesce();
    bus_wr(24'h2024, 8'h00);
    irq_src[7] = 1'b1;
    tick();
    irq_src = '0;
    expect_no_req(5, "mask_level3");
    cpu_level = 2'd2;
    tick();
    n_tests++;
    if (cpu_irq_req !== 1'b1 || cpu_irq_vector !== 5'd7) begin
      n_fail++;
      $display("FAIL mask_lowered: got req=%b vec=%0d expected 1/7", cpu_irq_req, cpu_irq_vector);
    end
  endtask

  task automatic test_withdrawal();
    bus_wr(24'h2023, 8'h00);
    tick();
    n_tests++;
    if (cpu_irq_req !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw: req got %b expected 0", cpu_irq_req);
    end
    expect_no_req(3, "withdraw_idle");
  endtask

  task automatic test_collision();
    quiesce();
    irq_src[7] = 1'b1;
    bus_wr(24'h2027, 8'h80);
    rd_check(24'h2027, "collision_set_wins");
    n_tests++;
    if (exp_byte(24'h2027) !== 8'h80) begin
      n_fail++;
      $display("FAIL collision_model: got %02h expected 80", exp_byte(24'h2027));
    end
    bus_wr(24'h2027, 8'h80);
    tick();
    tick();
    rd_check(24'h2027, "held_level_no_reset");
    irq_src[8] = 1'b1;
    tick();
    rd_check(24'h2028, "pending_ignores_enable");
    irq_src = '0;
    tick();
  endtask

  task automatic test_reset_mid_req();
    quiesce();
    bus_wr(24'h2023, 8'h80);
    cpu_level = 2'd0;
    irq_src[7] = 1'b1;
    tick();
    irq_src = '0;
    wait_req(4, "midreset_req");
    #10;
    reset = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (cpu_irq_req !== 1'b0 || cpu_irq_vector !== 5'd0 || cpu_irq_level !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got req=%b vec=%0d lvl=%0d expected 0/0/0",
               cpu_irq_req, cpu_irq_vector, cpu_irq_level);
    end
    for (int a = 32'h2020; a <= 32'h202A; a++) rd_check(24'(a), "midreset_regs");
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 30; r++) begin
      quiesce();
      for (int b = 0; b < 3; b++) bus_wr(24'h2020 + 24'(b), 8'($urandom));
      for (int b = 0; b < 4; b++) bus_wr(24'h2023 + 24'(b), 8'($urandom | $urandom));
      rd_check(24'h2022, "rand_prio_top");
      rd_check(24'h2020 + 24'($urandom_range(0, 6)), "rand_cfg");
      cpu_level = 2'($urandom_range(0, 3));
      irq_src = $urandom & $urandom;
      tick();
      irq_src = '0;
      for (int b = 0; b < 4; b++) rd_check(24'h2027 + 24'(b), "rand_pending");
      for (int k = 0; k < 33; k++) begin
        int w;
        w = model_winner();
        if (w < 0) begin
          expect_no_req(4, "rand_no_winner");
          break;
        end
        wait_req(4, "rand_req");
        n_tests++;
        if (cpu_irq_vector !== 5'(w) || cpu_irq_level !== 2'(prio_of(w))) begin
          n_fail++;
          $display("FAIL rand_winner round %0d: got vec=%0d lvl=%0d expected %0d/%0d",
                   r, cpu_irq_vector, cpu_irq_level, w, prio_of(w));
        end
        cpu_irq_ack = 1'b1;
        tick();
        cpu_irq_ack = 1'b0;
        n_tests++;
        if (cpu_irq_req !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_ack: req got %b expected 0", cpu_irq_req);
        end
        bus_wr(24'h2027 + 24'(w / 8), 8'(1 << (w % 8)));
      end
    end
  endtask

  initial begin
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    test_reset();
    test_single();
    test_arbitration();
    test_masking();
    test_withdrawal();
    test_collision();
    test_reset_mid_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Parametrised interrupt controller for the Pokemon Mini core. It latches rising edges from peripheral interrupt sources into pending flags and exposes priority, enable and pending registers on the CPU bus.
- It arbitrates among enabled pending sources by group priority against the CPU's current interrupt level. The winning vector is presented to the CPU through a req/ack handshake.
- It sits between the peripherals (timers, blitter, keypad, IR, 256 Hz clock) and the CPU core, and replaces the fixed 32-source prototype.

Parameters:
- NUM_SOURCES, 32, number of interrupt sources (1..32); vector = source index.
- NUM_GROUPS, 9, number of priority groups.
- PRIO_WIDTH, 2, bits per group priority; also the width of the CPU level.
- BASE_ADDR, 24'h2020, bus address of priority byte 0.
- Derived: PRIO_BYTES = ceil(NUM_GROUPS*PRIO_WIDTH/8) = 3; SRC_BYTES = ceil(NUM_SOURCES/8) = 4.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_src  in  NUM_SOURCES  raw peripheral interrupt lines; rising edge = event.
- bus_write  in  1  write strobe, sampled at the rising edge.
- bus_read  in  1  read strobe; informational, reads have no side effects.
- bus_address_in  in  24  bus address.
- bus_data_in  in  8  write data.
- bus_data_out  out  8  read data, combinational from bus_address_in.
- cpu_level  in  PRIO_WIDTH  current CPU interrupt mask level (I01).
- cpu_irq_req  out  1  interrupt request.
- cpu_irq_vector  out  5  winning source index.
- cpu_irq_level  out  PRIO_WIDTH  priority of the winning source.
- cpu_irq_ack  in  1  CPU accepted the request (single-cycle pulse).

Behaviour:
- Reset (async assert, sync-free deassert):
  - priority, enable, pending and edge-history registers = 0; FSM = IDLE.
  - cpu_irq_req = 0, cpu_irq_vector = 0, cpu_irq_level = 0.
- Register map, byte-addressed from BASE_ADDR:
  - PRIO_BYTES priority bytes, then SRC_BYTES enable bytes, then SRC_BYTES pending bytes.
  - Default map is 2020-2022 priority, 2023-2026 enable, 2027-202A pending.
  - Bits beyond NUM_GROUPS*PRIO_WIDTH or NUM_SOURCES read 0 and ignore writes.
  - Addresses outside the map read 8'h00.
- Priority and enable bytes: plain read/write. A write takes effect at the edge where bus_write=1.
- Pending bytes are write-1-to-clear; writing 0 leaves the bit unchanged.
- Edge detect: pending[i] sets when irq_src[i]=1 and the registered previous value = 0. A level held high sets pending only once.
- Pending sets regardless of enable. Enable gates arbitration only.
- Same-cycle set and W1C clear on the same bit: set wins.
- Group of source i comes from the package table SRC_GROUP[i]. prio(i) = priority field of that group.
- Eligible(i) = pending[i] & enable[i] & prio(i) != 0 & prio(i) > cpu_level.
- Winner: highest prio(i) among eligible sources; ties go to the lowest index. The winner is registered (1-cycle arbitration latency).
- FSM:
  - IDLE: if any source is eligible, register the winner into vector/level, go to REQ (cpu_irq_req=1 the next cycle).
  - REQ: cpu_irq_req=1, vector/level held stable.
    - On cpu_irq_ack, go to ACKED.
    - If the held source stops being eligible (cleared, disabled, or cpu_level raised) before ack, drop req and go to IDLE.
    - A higher-priority source arriving in REQ does not pre-empt; it is served after return to IDLE.
  - ACKED: req=0 for one cycle (lets the CPU level update), then IDLE.
- Acknowledge does not clear pending; software clears it via W1C.
- ack outside REQ is ignored.
- Reset mid-request drops req immediately (async).

Decomposition:
- Shared package pm_irq_pkg holds:
  - SRC_GROUP table (default: NMI 0-2 → group 0, blitter 3-4 → 3, tim3/2 → 2, tim1/0 → 1, tim5/4 → 0, 256 Hz 11-14 → 7, IR/shock 15-18 → 8, K1x 19-20 → 6, K0x 21-28 → 5, 29-31 → 4).
  - irq_fsm_t enum {IDLE, REQ, ACKED}.
  - Register offset constants.
- One sub-module, irq_priority_select: combinational eligible-vector plus priorities → winner index, level, valid.

Test Plan:
- Reset values: assert reset low mid-REQ → cpu_irq_req=0 immediately; reading 2020-202A returns 8'h00.
- Single source: write 2020=8'h0C (group1 prio 3), enable bit 7 via 2023=8'h80, cpu_level=0, pulse irq_src[7] → pending 2027 reads 8'h80; req=1 two cycles after the edge with vector=7, level=3; ack → req low one cycle; write 2027=8'h80 → pending 0, no further req.
- Arbitration: sources 3 (prio 1) and 7 (prio 3) pend together → vector 7. Sources 7 and 8 both prio 3 → vector 7 (lowest index wins).
- Masking: cpu_level=3 with source prio 3 pending → no req. Lower cpu_level to 2 → req next arbitration.
- Withdrawal: in REQ, clear enable bit of the held source → req drops within 1 cycle, FSM IDLE.
- Set/clear collision: W1C write to 2027=8'h80 in the same cycle as a new rising edge on irq_src[7] → pending[7] remains 1; a held-high level does not re-set pending after a clear.
